// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared operation and FSM encodings
// for the iterative multiply/divide unit.
package mult_div_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } md_state_e;

   function automatic logic op_is_div(logic [1:0] o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(logic [1:0] o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

endpackage

// File: rtl/mult_div.sv
// mult_div: iterative shift-add multiplier and restoring
// divider sharing one 2*WIDTH+1 bit working register.
module mult_div
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam int W2 = 2 * WIDTH;

   md_state_e state, state_nxt;

   logic [W2:0]      work;
   logic [WIDTH-1:0] opnd;
   logic [CW-1:0]    count;
   logic             div_q;
   logic             neg_q;
   logic             neg_r;
   logic             dz_q;

   logic             accept;
   logic             finish;
   logic             sgn_in;
   logic             div_in;
   logic             dz_in;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   logic [WIDTH:0]   mul_sum;
   logic [W2:0]      mul_next;
   logic [W2:0]      div_sh;
   logic             div_ge;
   logic [WIDTH:0]   div_rem;
   logic [W2:0]      div_next;
   logic [W2:0]      step_next;

   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   assign busy = (state != S_IDLE);

   // Decode the request and take operand magnitudes.
   always_comb begin
      sgn_in = op_is_signed(op);
      div_in = op_is_div(op);
      dz_in  = div_in && (b == '0);
      a_mag  = (sgn_in && a[WIDTH-1]) ? -a : a;
      b_mag  = (sgn_in && b[WIDTH-1]) ? -b : b;
   end

   // One multiply or divide iteration on the working register.
   always_comb begin
      mul_sum  = {work[W2], work[W2-1:WIDTH]}
               + (work[0] ? {1'b0, opnd} : '0);
      mul_next = {1'b0, mul_sum, work[WIDTH-1:1]};
      div_sh   = {work[W2-1:0], 1'b0};
      div_ge   = (div_sh[W2:WIDTH] >= {1'b0, opnd});
      div_rem  = div_sh[W2:WIDTH] - {1'b0, opnd};
      div_next = div_ge
               ? {div_rem, div_sh[WIDTH-1:1], 1'b1}
               : div_sh;
      step_next = div_q ? div_next : mul_next;
   end

   // Sign correction of the unsigned magnitude results.
   always_comb begin
      prod_fix = neg_q ? -work[W2-1:0] : work[W2-1:0];
      quo_fix  = neg_q ? -work[WIDTH-1:0]
                       : work[WIDTH-1:0];
      rem_fix  = neg_r ? -work[W2-1:WIDTH]
                       : work[W2-1:WIDTH];
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // FSM next-state and control strobes.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = dz_in ? S_FIX : S_RUN;
            end
         end
         S_RUN: begin
            if (count == CW'(WIDTH - 1))
               state_nxt = S_FIX;
         end
         S_FIX: begin
            finish    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Working registers: load on accept, iterate in RUN.
   always_ff @(posedge clock) begin
      if (!reset) begin
         work  <= '0;
         opnd  <= '0;
         count <= '0;
         div_q <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz_q  <= 1'b0;
      end else if (accept) begin
         work  <= {{(WIDTH+1){1'b0}},
                   div_in ? a_mag : b_mag};
         opnd  <= div_in ? b_mag : a_mag;
         count <= '0;
         div_q <= div_in;
         neg_q <= sgn_in && (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_r <= sgn_in && div_in && a[WIDTH-1];
         dz_q  <= dz_in;
      end else if (state == S_RUN) begin
         work  <= step_next;
         count <= count + CW'(1);
      end
   end

   // Result registers, written only on completion.
   always_ff @(posedge clock) begin
      if (!reset) begin
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else begin
         done <= finish;
         if (finish) begin
            if (dz_q) begin
               div_zero <= 1'b1;
            end else begin
               div_zero <= 1'b0;
               if (div_q) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[W2-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
            end
         end
      end
   end

endmodule
